microcpu_w: RTL and testbench

MICROCPU_W -- requirements
Module: microcpu_w

---
 rtl/microcpu_w.sv | 147 ++++++++++++++
 tb/tb_microcpu_w.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microcpu_w.sv
// microcpu_w: two-word-instruction micro CPU with sixteen DW-bit registers (r15 = PC)
// and a single memory port that completes an access on any cycle with ready high.
module microcpu_w #(
  parameter int            DW       = 8,
  parameter logic [DW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          read,
  output logic          write,
  output logic [DW-1:0] address,
  output logic [DW-1:0] dout,
  input  logic [DW-1:0] din,
  input  logic          ready,
  output logic          halted
);

  typedef enum logic [1:0] {FETCH_OP, FETCH_ARG, MEM, HALT} state_t;

  localparam logic [3:0] OP_EXT   = 4'd0;
  localparam logic [3:0] OP_LOAD  = 4'd1;
  localparam logic [3:0] OP_STORE = 4'd2;
  localparam logic [3:0] OP_SET   = 4'd3;
  localparam logic [3:0] OP_LT    = 4'd4;
  localparam logic [3:0] OP_EQ    = 4'd5;
  localparam logic [3:0] OP_BEQ   = 4'd6;
  localparam logic [3:0] OP_BNEQ  = 4'd7;
  localparam logic [3:0] OP_ADD   = 4'd8;
  localparam logic [3:0] OP_SUB   = 4'd9;
  localparam logic [3:0] OP_SHL   = 4'd10;
  localparam logic [3:0] OP_SHR   = 4'd11;
  localparam logic [3:0] OP_AND   = 4'd12;
  localparam logic [3:0] OP_OR    = 4'd13;
  localparam logic [3:0] OP_INV   = 4'd14;
  localparam logic [3:0] OP_XOR   = 4'd15;

  state_t        state;
  logic [3:0]    op, dest;
  logic [DW-1:0] regs [16];

  logic [3:0]        arg1, arg2;
  logic [7:0]        cnst;
  logic signed [7:0] cnst_s;
  logic [DW-1:0]     pc, ra, rb, rd, ea, npc, wr_val;
  logic              wr_en;

  function automatic logic [DW-1:0] alu(input logic [3:0] f, input logic [DW-1:0] a,
                                        input logic [DW-1:0] b, input logic [7:0] c);
    case (f)
      OP_SET:  alu = DW'(c);
      OP_LT:   alu = DW'(a < b);
      OP_EQ:   alu = DW'(a == b);
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      // shift counts of DW or more flush the operand entirely
      OP_SHL:  alu = (32'(b) >= DW) ? '0 : a << b;
      OP_SHR:  alu = (32'(b) >= DW) ? '0 : a >> b;
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      OP_INV:  alu = ~a;
      OP_XOR:  alu = a ^ b;
      default: alu = '0;
    endcase
  endfunction

  assign pc = regs[15];

  // Arg-word decode and execute; pc here is already the arg-word address.
  always_comb begin
    arg1   = din[7:4];
    arg2   = din[3:0];
    cnst   = din[7:0];
    cnst_s = signed'(cnst);
    ra     = regs[arg1];
    rb     = regs[arg2];
    rd     = regs[dest];
    ea     = ra + DW'(arg2);
    wr_val = alu(op, ra, rb, cnst);
    wr_en  = 1'b0;
    npc    = pc + DW'(1);
    case (op)
      OP_EXT:            if (dest == 4'd1) npc = pc + DW'(cnst_s);
      OP_BEQ:            if (rd == DW'(cnst)) npc = pc + DW'(3);
      OP_BNEQ:           if (rd != DW'(cnst)) npc = pc + DW'(3);
      OP_LOAD, OP_STORE: ;
      default:           wr_en = 1'b1;
    endcase
    if (wr_en && dest == 4'd15) npc = wr_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH_OP;
      for (int i = 0; i < 15; i++) regs[i] <= '0;
      regs[15] <= RESET_PC;
      op       <= '0;
      dest     <= '0;
      read     <= 1'b1;
      write    <= 1'b0;
      address  <= RESET_PC;
      dout     <= '0;
      halted   <= 1'b0;
    end else begin
      case (state)
        FETCH_OP: if (ready) begin
          op       <= din[7:4];
          dest     <= din[3:0];
          regs[15] <= pc + DW'(1);
          address  <= pc + DW'(1);
          state    <= FETCH_ARG;
        end
        FETCH_ARG: if (ready) begin
          if (op == OP_LOAD || op == OP_STORE) begin
            regs[15] <= npc;
            address  <= ea;
            read     <= (op == OP_LOAD);
            write    <= (op == OP_STORE);
            dout     <= rd;
            state    <= MEM;
          end else if (op == OP_EXT && dest == 4'd2) begin
            read   <= 1'b0;
            halted <= 1'b1;
            state  <= HALT;
          end else begin
            if (wr_en) regs[dest] <= wr_val;
            regs[15] <= npc;
            address  <= npc;
            state    <= FETCH_OP;
          end
        end
        MEM: if (ready) begin
          if (op == OP_LOAD) begin
            regs[dest] <= din;
            address    <= (dest == 4'd15) ? din : pc;
          end else begin
            address <= pc;
          end
          read  <= 1'b1;
          write <= 1'b0;
          state <= FETCH_OP;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_microcpu_w.sv
// Bench for microcpu_w: directed scenarios plus random programs checked against an
// instruction-level reference interpreter; one DW=8 and one DW=16 core share clk/rst.
module tb_microcpu_w;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd8, wr8, hl8, rdy8;
  logic [7:0] a8, do8, di8;
  logic rd16, wr16, hl16, rdy16;
  logic [15:0] a16, do16, di16;

  logic [31:0] mem [2][256];
  longint mm [256];
  longint mr [16];
  int tests = 0, fails = 0, excl_err = 0;
  bit rnd_rdy = 1'b0;
  int rnd_sel = 0;
  int wcnt8 = 0;
  logic [7:0] waddr8, wdata8;
  logic wread8;

  always #5 clk = ~clk;
  assign di8  = mem[0][a8][7:0];
  assign di16 = mem[1][a16[7:0]][15:0];

  microcpu_w #(.DW(8), .RESET_PC(8'h00)) u8 (
    .clk(clk), .rst(rst), .read(rd8), .write(wr8), .address(a8), .dout(do8),
    .din(di8), .ready(rdy8), .halted(hl8));

  microcpu_w #(.DW(16), .RESET_PC(16'h0040)) u16 (
    .clk(clk), .rst(rst), .read(rd16), .write(wr16), .address(a16), .dout(do16),
    .din(di16), .ready(rdy16), .halted(hl16));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    logic w8, w16, r8s;
    logic [7:0] wa8, wd8;
    logic [15:0] wa16, wd16;
    if (rnd_rdy) begin
      if (rnd_sel == 0) rdy8 = ($urandom_range(0, 3) != 0);
      else              rdy16 = ($urandom_range(0, 3) != 0);
    end
    if (rd8 && wr8) excl_err++;
    if (rd16 && wr16) excl_err++;
    w8 = wr8 & rdy8 & ~rst;  wa8 = a8;  wd8 = do8;  r8s = rd8;
    w16 = wr16 & rdy16 & ~rst; wa16 = a16; wd16 = do16;
    @(posedge clk);
    #1;
    if (w8) begin
      mem[0][wa8] = {24'h0, wd8};
      wcnt8++; waddr8 = wa8; wdata8 = wd8; wread8 = r8s;
    end
    if (w16) mem[1][wa16[7:0]] = {16'h0, wd16};
  endtask

  task automatic clear(input int w);
    for (int i = 0; i < 256; i++) mem[w][i] = 32'h0;
  endtask

  task automatic load(input int w, input int base, input int n, input logic [127:0] p);
    for (int i = 0; i < n; i++) mem[w][base + i] = {24'h0, p[127 - 8*i -: 8]};
  endtask

  // SET r0,0xC0; STORE ri,[r0+i] for i=1..14; HALT
  task automatic put_dump(input int w, input int base);
    mem[w][base] = 32'h30;
    mem[w][base + 1] = 32'hC0;
    for (int i = 1; i < 15; i++) begin
      mem[w][base + 2*i] = 32'h20 + 32'(i);
      mem[w][base + 2*i + 1] = 32'(i);
    end
    mem[w][base + 30] = 32'h02;
    mem[w][base + 31] = 32'h00;
  endtask

  task automatic run_halt(input int w, input int budget, output int cyc);
    cyc = 0;
    while (((w == 0) ? hl8 : hl16) !== 1'b1 && cyc < budget) begin
      tick();
      cyc++;
    end
    tests++;
    if (((w == 0) ? hl8 : hl16) !== 1'b1) begin
      fails++;
      $display("FAIL halt_timeout w=%0d: halted=0 after %0d cycles, required halted=1", w, cyc);
    end
  endtask

  task automatic model_run(input int w, input int dw, input longint start);
    longint mask, pc, a, nxt, val, ea, c;
    int op, dest, a1, a2, steps;
    bit wr, halt;
    mask = (longint'(1) << dw) - 1;
    for (int i = 0; i < 256; i++) mm[i] = longint'(mem[w][i]) & mask;
    for (int i = 0; i < 16; i++) mr[i] = 0;
    pc = start; halt = 1'b0; steps = 0;
    while (!halt && steps < 1000) begin
      op   = int'((mm[pc & 255] >> 4) & 15);
      dest = int'(mm[pc & 255] & 15);
      a    = (pc + 1) & mask;
      c    = mm[a & 255] & 255;
      a1   = int'(c >> 4);
      a2   = int'(c & 15);
      nxt  = (a + 1) & mask;
      wr = 1'b0; val = 0;
      ea = (mr[a1] + a2) & mask;
      case (op)
        0:  if (dest == 1) nxt = (a + ((c >= 128) ? c - 256 : c)) & mask;
            else if (dest == 2) halt = 1'b1;
        1:  begin val = mm[ea & 255]; wr = 1'b1; end
        2:  mm[ea & 255] = mr[dest];
        3:  begin val = c; wr = 1'b1; end
        4:  begin val = (mr[a1] < mr[a2]) ? 1 : 0; wr = 1'b1; end
        5:  begin val = (mr[a1] == mr[a2]) ? 1 : 0; wr = 1'b1; end
        6:  if (mr[dest] == c) nxt = (a + 3) & mask;
        7:  if (mr[dest] != c) nxt = (a + 3) & mask;
        8:  begin val = (mr[a1] + mr[a2]) & mask; wr = 1'b1; end
        9:  begin val = (mr[a1] - mr[a2]) & mask; wr = 1'b1; end
        10: begin val = (mr[a2] >= dw) ? 0 : (mr[a1] << mr[a2]) & mask; wr = 1'b1; end
        11: begin val = (mr[a2] >= dw) ? 0 : (mr[a1] >> mr[a2]); wr = 1'b1; end
        12: begin val = mr[a1] & mr[a2]; wr = 1'b1; end
        13: begin val = mr[a1] | mr[a2]; wr = 1'b1; end
        14: begin val = (~mr[a1]) & mask; wr = 1'b1; end
        default: begin val = mr[a1] ^ mr[a2]; wr = 1'b1; end
      endcase
      if (wr) begin
        if (dest == 15) nxt = val;
        else mr[dest] = val;
      end
      if (!halt) pc = nxt;
      steps++;
    end
    tests++;
    if (!halt) begin
      fails++;
      $display("FAIL model_halt w=%0d: model ran %0d steps without HALT, required HALT", w, steps);
    end
  endtask

  task automatic gen_random(input int w, input int base);
    int ops [15] = '{0, 1, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    int addr, op, dest, a1, a2;
    logic [7:0] arg;
    clear(w);
    for (int i = 0; i < 16; i++)
      mem[w][i] = (w == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 65535));
    addr = base;
    for (int n = 0; n < 20; n++) begin
      op   = ops[$urandom_range(0, 14)];
      dest = int'($urandom_range(1, 14));
      a1   = int'($urandom_range(0, 14));
      a2   = int'($urandom_range(0, 14));
      arg  = {4'(a1), 4'(a2)};
      case (op)
        0:       dest = 3;
        1:       arg = {4'h0, 4'($urandom_range(0, 15))};
        3:       arg = 8'($urandom_range(0, 255));
        6, 7:    arg = 8'($urandom_range(0, 2));
        default: ;
      endcase
      mem[w][addr]     = {24'h0, 4'(op), 4'(dest)};
      mem[w][addr + 1] = {24'h0, arg};
      addr += 2;
    end
    mem[w][addr] = 32'h0;
    mem[w][addr + 1] = 32'h0;
    put_dump(w, addr + 2);
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy8 = 1'b0; rdy16 = 1'b0;
    tick(); tick();
    tests += 4;
    if ({rd8, wr8, hl8} !== 3'b100) begin fails++;
      $display("FAIL reset_ctl8: read/write/halted=%b, required 100", {rd8, wr8, hl8}); end
    if (a8 !== 8'h00) begin fails++;
      $display("FAIL reset_addr8: address=%h, required 00", a8); end
    if ({rd16, wr16, hl16} !== 3'b100) begin fails++;
      $display("FAIL reset_ctl16: read/write/halted=%b, required 100", {rd16, wr16, hl16}); end
    if (a16 !== 16'h0040) begin fails++;
      $display("FAIL reset_addr16: address=%h, required 0040", a16); end
  endtask

  task automatic test_store_basic();
    rst = 1'b1; tick();
    clear(0);
    load(0, 0, 10, {80'h31053203831223040200, 48'h0});
    rdy8 = 1'b1; wcnt8 = 0;
    rst = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 10) begin tests++;
        if (hl8 !== 1'b0) begin fails++;
          $display("FAIL latency_early: halted=%b at cycle 10, required 0", hl8); end
      end
      if (k == 11) begin tests++;
        if (hl8 !== 1'b1) begin fails++;
          $display("FAIL latency_halt: halted=%b at cycle 11, required 1", hl8); end
      end
    end
    tests += 2;
    if (wcnt8 !== 1) begin fails++;
      $display("FAIL store_count: write cycles=%0d, required 1", wcnt8); end
    if ({waddr8, wdata8, wread8} !== {8'h04, 8'h08, 1'b0}) begin fails++;
      $display("FAIL store_data: addr=%h dout=%h read=%b, required addr=04 dout=08 read=0",
               waddr8, wdata8, wread8); end
  endtask

  task automatic test_halt();
    for (int k = 0; k < 20; k++) begin
      tick(); tests++;
      if ({hl8, rd8, wr8, a8} !== {3'b100, 8'h09}) begin fails++;
        $display("FAIL halt_hold: halted/read/write=%b address=%h, required 100 address=09",
                 {hl8, rd8, wr8}, a8); end
    end
    rst = 1'b1; tick(); rst = 1'b0;
    tests++;
    if ({hl8, rd8, a8} !== {2'b01, 8'h00}) begin fails++;
      $display("FAIL halt_exit: halted/read=%b address=%h, required 01 address=00", {hl8, rd8}, a8); end
    tick(); tests++;
    if ({rd8, a8} !== {1'b1, 8'h01}) begin fails++;
      $display("FAIL halt_refetch: read=%b address=%h, required read=1 address=01", rd8, a8); end
  endtask

  task automatic test_ready_hold();
    int cyc;
    rst = 1'b1; tick();
    clear(0);
    load(0, 0, 6, {48'h317F210F0200, 80'h0});
    rdy8 = 1'b1; rst = 1'b0;
    tick(); tests++;
    if (a8 !== 8'h01) begin fails++; $display("FAIL wait_pre: address=%h, required 01", a8); end
    rdy8 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(); tests++;
      if ({rd8, a8} !== {1'b1, 8'h01}) begin fails++;
        $display("FAIL wait_hold: read=%b address=%h, required read=1 address=01", rd8, a8); end
    end
    rdy8 = 1'b1;
    tick(); tests++;
    if (a8 !== 8'h02) begin fails++; $display("FAIL wait_resume: address=%h, required 02", a8); end
    run_halt(0, 40, cyc);
    tests++;
    if (mem[0][15] !== 32'h7F) begin fails++;
      $display("FAIL wait_r1: r1 stored=%h, required 7f", mem[0][15]); end
  endtask

  task automatic test_load_branch16();
    int cyc;
    rdy8 = 1'b0;
    rst = 1'b1; tick();
    clear(1);
    mem[1][16'h10] = 32'hBEEF;
    load(1, 16'h40, 8, {64'h35101450240E0200, 64'h0});
    rdy16 = 1'b1; rst = 1'b0;
    run_halt(1, 40, cyc);
    tests += 2;
    if (mem[1][8'h0E] !== 32'hBEEF) begin fails++;
      $display("FAIL load_r4: r4 stored=%h, required beef", mem[1][8'h0E]); end
    if (cyc !== 10) begin fails++;
      $display("FAIL load_latency: cycles to halt=%0d, required 10", cyc); end
    rst = 1'b1; tick();
    load(1, 16'h40, 2, {16'h01CF, 112'h0});
    load(1, 16'h10, 2, {16'h01FE, 112'h0});
    load(1, 16'h0F, 1, {8'h02, 120'h0});
    rst = 1'b0;
    tick(); tick(); tests++;
    if (a16 !== 16'h0010) begin fails++;
      $display("FAIL branch_back: address=%h, required 0010", a16); end
    tick(); tick(); tests++;
    if (a16 !== 16'h000F) begin fails++;
      $display("FAIL branch_neg: address=%h, required 000f", a16); end
    run_halt(1, 10, cyc); tests++;
    if (a16 !== 16'h0010) begin fails++;
      $display("FAIL halt_addr16: address=%h, required 0010", a16); end
    rdy16 = 1'b0;
  endtask

  task automatic test_branch();
    logic [7:0] opw [4] = '{8'h61, 8'h71, 8'h61, 8'h71};
    logic [7:0] cw  [4] = '{8'h05, 8'h05, 8'h06, 8'h06};
    logic [7:0] exp [4] = '{8'h24, 8'h22, 8'h22, 8'h24};
    rdy8 = 1'b1;
    for (int t = 0; t < 4; t++) begin
      rst = 1'b1; tick();
      clear(0);
      load(0, 0, 4, {32'h3105011D, 96'h0});
      mem[0][8'h20] = {24'h0, opw[t]};
      mem[0][8'h21] = {24'h0, cw[t]};
      load(0, 8'h22, 4, {32'h02000200, 96'h0});
      rst = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      tests++;
      if (a8 !== exp[t]) begin fails++;
        $display("FAIL branch_%0d: op=%h const=%h next fetch=%h, required %h", t, opw[t], cw[t], a8, exp[t]); end
    end
    rst = 1'b1; tick();
    load(0, 0, 2, {16'h01F0, 112'h0});
    rst = 1'b0;
    tick(); tick(); tests++;
    if (a8 !== 8'hF1) begin fails++;
      $display("FAIL pc_wrap: address=%h, required f1", a8); end
  endtask

  task automatic test_rst_mem();
    int cyc;
    rst = 1'b1; tick();
    clear(0);
    load(0, 0, 6, {48'h31113E22210F, 80'h0});
    rdy8 = 1'b1; rst = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    tests++;
    if ({wr8, rd8, a8, do8} !== {2'b10, 8'h0F, 8'h11}) begin fails++;
      $display("FAIL mem_enter: write/read=%b address=%h dout=%h, required 10 address=0f dout=11",
               {wr8, rd8}, a8, do8); end
    rdy8 = 1'b0;
    tick(); tick(); tests++;
    if ({wr8, a8, do8} !== {1'b1, 8'h0F, 8'h11}) begin fails++;
      $display("FAIL mem_hold: write=%b address=%h dout=%h, required 1 0f 11", wr8, a8, do8); end
    rst = 1'b1; tick();
    tests += 2;
    if ({wr8, a8} !== {1'b0, 8'h00}) begin fails++;
      $display("FAIL rst_abort: write=%b address=%h, required write=0 address=00", wr8, a8); end
    if (mem[0][15] !== 32'h0) begin fails++;
      $display("FAIL rst_nowrite: mem[0f]=%h, required 0", mem[0][15]); end
    clear(0);
    for (int i = 0; i < 16; i++) mem[0][8'hC0 + i] = 32'hFF;
    put_dump(0, 0);
    rdy8 = 1'b1; rst = 1'b0;
    run_halt(0, 200, cyc);
    for (int i = 1; i < 15; i++) begin
      tests++;
      if (mem[0][8'hC0 + i] !== 32'h0) begin fails++;
        $display("FAIL rst_reg r%0d: value=%h, required 0", i, mem[0][8'hC0 + i]); end
    end
  endtask

  task automatic test_random();
    int cyc;
    for (int w = 0; w < 2; w++) begin
      for (int it = 0; it < 6; it++) begin
        rdy8 = 1'b0; rdy16 = 1'b0;
        rst = 1'b1; tick();
        gen_random(w, (w == 0) ? 0 : 16'h40);
        model_run(w, (w == 0) ? 8 : 16, (w == 0) ? 0 : 16'h40);
        rnd_sel = w; rnd_rdy = 1'b1; rst = 1'b0;
        run_halt(w, 3000, cyc);
        rnd_rdy = 1'b0;
        for (int i = 1; i < 15; i++) begin
          tests++;
          if (mem[w][8'hC0 + i] !== 32'(mm[8'hC0 + i])) begin fails++;
            $display("FAIL random w=%0d it=%0d r%0d: got %h, required %h",
                     w, it, i, mem[w][8'hC0 + i], 32'(mm[8'hC0 + i])); end
        end
      end
    end
  endtask

  task automatic test_exclusive();
    tests++;
    if (excl_err !== 0) begin fails++;
      $display("FAIL rw_exclusive: cycles with read and write both high=%0d, required 0", excl_err); end
  endtask

  initial begin
    test_reset();
    test_store_basic();
    test_halt();
    test_ready_hold();
    test_load_branch16();
    test_branch();
    test_rst_mem();
    test_random();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
